// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame decoder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_CMD,
    S_AH,
    S_AL,
    S_DATA,
    S_CSUM,
    S_FILL
  } state_e;

  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_FILL      = 8'h02;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Frame payload latched between SYNC and CSUM.
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr_h;
    logic [7:0] addr_l;
    logic [7:0] data;
  } frame_t;

  function automatic logic [7:0] frame_csum(input frame_t f);
    return f.cmd ^ f.addr_h ^ f.addr_l ^ f.data;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Saturating inter-byte idle counter; flags expiry once TIMEOUT_CYC idle clocks have elapsed.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses 6-byte SYNC/CMD/ADDR_H/ADDR_L/DATA/CSUM frames from the byte receiver
// into framebuffer writes: a single pixel write or a linear fill from address 0.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_ok,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_ok,
  output logic              err_csum,
  output logic              err_cmd,
  output logic              err_timeout,
  output logic              err_overrun
);

  logic              ok_q;
  state_e            state_q, state_d;
  frame_t            frame_q, frame_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_ok_q, frame_ok_d;
  logic              err_csum_q, err_csum_d;
  logic              err_cmd_q, err_cmd_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_overrun_q, err_overrun_d;

  logic              accept_c;
  logic              in_frame_c;
  logic              timeout_c;
  logic [ADDR_W-1:0] last_addr_c;

  // One accept per byte, on the rising edge of the valid level.
  assign accept_c    = rx_byte_ok & ~ok_q;
  assign in_frame_c  = (state_q == S_CMD) || (state_q == S_AH) || (state_q == S_AL) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
  assign last_addr_c = ADDR_W'({frame_q.addr_h, frame_q.addr_l});

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept_c | ~in_frame_c),
    .en       (in_frame_c),
    .expired_c(timeout_c)
  );

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    fill_addr_d   = fill_addr_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    busy_d        = 1'b0;
    frame_ok_d    = 1'b0;
    err_csum_d    = 1'b0;
    err_cmd_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    unique case (state_q)
      S_SYNC: begin
        if (accept_c && (rx_byte == SYNC_BYTE)) state_d = S_CMD;
      end
      S_CMD, S_AH, S_AL, S_DATA: begin
        if (accept_c) begin
          case (state_q)
            S_CMD:   begin frame_d.cmd    = rx_byte; state_d = S_AH;   end
            S_AH:    begin frame_d.addr_h = rx_byte; state_d = S_AL;   end
            S_AL:    begin frame_d.addr_l = rx_byte; state_d = S_DATA; end
            default: begin frame_d.data   = rx_byte; state_d = S_CSUM; end
          endcase
        end else if (timeout_c) begin
          err_timeout_d = 1'b1;
          state_d       = S_SYNC;
        end
      end
      S_CSUM: begin
        if (accept_c) begin
          state_d = S_SYNC;
          if (rx_byte != frame_csum(frame_q)) begin
            err_csum_d = 1'b1;
          end else if (frame_q.cmd == CMD_WRITE) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = last_addr_c;
            wr_data_d  = frame_q.data;
            frame_ok_d = 1'b1;
          end else if (frame_q.cmd == CMD_FILL) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = '0;
            wr_data_d   = frame_q.data;
            busy_d      = 1'b1;
            frame_ok_d  = 1'b1;
            fill_addr_d = '0;
            state_d     = S_FILL;
          end else begin
            err_cmd_d = 1'b1;
          end
        end else if (timeout_c) begin
          err_timeout_d = 1'b1;
          state_d       = S_SYNC;
        end
      end
      S_FILL: begin
        // fill_addr_q is the address currently on the write port; stop on compare, never on wrap.
        if (accept_c) err_overrun_d = 1'b1;
        if (fill_addr_q == last_addr_c) begin
          state_d = S_SYNC;
        end else begin
          fill_addr_d = fill_addr_q + ADDR_W'(1);
          wr_en_d     = 1'b1;
          wr_addr_d   = fill_addr_q + ADDR_W'(1);
          busy_d      = 1'b1;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q          <= 1'b0;
      state_q       <= S_SYNC;
      frame_q       <= '0;
      fill_addr_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_ok_q    <= 1'b0;
      err_csum_q    <= 1'b0;
      err_cmd_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      ok_q          <= rx_byte_ok;
      state_q       <= state_d;
      frame_q       <= frame_d;
      fill_addr_q   <= fill_addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      frame_ok_q    <= frame_ok_d;
      err_csum_q    <= err_csum_d;
      err_cmd_q     <= err_cmd_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign frame_ok    = frame_ok_q;
  assign err_csum    = err_csum_q;
  assign err_cmd     = err_cmd_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder: frames driven as held byte levels,
// outputs tallied on the falling edge and compared with hand-computed expectations.
module tb_uart_cmd_decoder;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned TIMEOUT_CYC = 50000;
  localparam int          HOLD        = 30;
  localparam int          GAP         = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_byte_ok = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_ok;
  logic              err_csum;
  logic              err_cmd;
  logic              err_timeout;
  logic              err_overrun;

  uart_cmd_decoder #(
    .ADDR_W     (ADDR_W),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_byte_ok (rx_byte_ok),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_ok   (frame_ok),
    .err_csum   (err_csum),
    .err_cmd    (err_cmd),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-test tallies, gathered on the falling edge.
  int         wr_cnt, ok_cnt, ok_wr_cnt, csum_cnt, cmd_cnt, to_cnt, ovr_cnt, busy_cnt;
  int         last_acc, first_wr_lat, first_wr_cyc, last_wr_cyc, to_lat;
  logic       prev_ok = 1'b0;
  logic [15:0] addr_log[$];
  logic [7:0]  data_log[$];

  always @(negedge clk) begin
    if (rx_byte_ok && !prev_ok) last_acc = cyc;
    prev_ok = rx_byte_ok;
    if (wr_en) begin
      if (wr_cnt == 0) begin
        first_wr_lat = cyc - last_acc;
        first_wr_cyc = cyc;
      end
      last_wr_cyc = cyc;
      wr_cnt++;
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
    end
    if (frame_ok) begin
      ok_cnt++;
      if (wr_en) ok_wr_cnt++;
    end
    if (err_csum) csum_cnt++;
    if (err_cmd) cmd_cnt++;
    if (err_timeout) begin
      if (to_cnt == 0) to_lat = cyc - last_acc;
      to_cnt++;
    end
    if (err_overrun) ovr_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_tally();
    wr_cnt = 0; ok_cnt = 0; ok_wr_cnt = 0; csum_cnt = 0; cmd_cnt = 0;
    to_cnt = 0; ovr_cnt = 0; busy_cnt = 0;
    first_wr_lat = -1; first_wr_cyc = 0; last_wr_cyc = 0; to_lat = -1;
    addr_log.delete();
    data_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte    = b;
    rx_byte_ok = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1 rx_byte_ok = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 5; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single pixel write of 5A to 1234 with no other activity.
  task automatic expect_frame1(input string tag);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd1);
    check({tag, "_wr_addr"}, 32'(addr_log.size() > 0 ? addr_log[0] : 16'h0), 32'h1234);
    check({tag, "_wr_data"}, 32'(data_log.size() > 0 ? data_log[0] : 8'h0), 32'h5A);
    check({tag, "_ok_with_wr"}, 32'(ok_wr_cnt), 32'd1);
    check({tag, "_errs"}, 32'(csum_cnt + cmd_cnt + to_cnt + ovr_cnt), 32'd0);
  endtask

  localparam logic [47:0] FRAME1 = 48'hA5_01_12_34_5A_7D;

  initial begin
    int bad_addr;
    int bad_data;
    int wait_cyc;

    clear_tally();
    #1;
    check("rst_flags", 32'({wr_en, busy, frame_ok, err_csum, err_cmd, err_timeout, err_overrun}), 32'd0);
    check("rst_addr_data", 32'({wr_addr, wr_data}), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // 1: single pixel write, 1-cycle latency from last accept.
    clear_tally();
    send_frame(FRAME1);
    idle(10);
    expect_frame1("t1");
    check("t1_latency", 32'(first_wr_lat), 32'd1);

    // 2: fill 0..3 with FF.
    clear_tally();
    send_frame(48'hA5_02_00_03_FF_FE);
    idle(20);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t2_busy_cyc", 32'(busy_cnt), 32'd4);
    check("t2_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd3);
    check("t2_latency", 32'(first_wr_lat), 32'd1);
    bad_addr = 0;
    bad_data = 0;
    foreach (addr_log[i]) begin
      if (addr_log[i] != 16'(i)) bad_addr++;
      if (data_log[i] != 8'hFF) bad_data++;
    end
    check("t2_addr_seq", 32'(bad_addr), 32'd0);
    check("t2_data", 32'(bad_data), 32'd0);
    check("t2_frame_ok", 32'(ok_cnt), 32'd1);
    check("t2_idle_after", 32'({wr_en, busy}), 32'd0);

    // 3: bad checksum, then a good frame.
    clear_tally();
    send_frame(48'hA5_01_12_34_5A_00);
    idle(10);
    check("t3_err_csum", 32'(csum_cnt), 32'd1);
    check("t3_no_wr", 32'(wr_cnt + ok_cnt), 32'd0);
    clear_tally();
    send_frame(FRAME1);
    idle(10);
    expect_frame1("t3b");

    // 4: unknown command with good checksum; then garbage ahead of SYNC.
    clear_tally();
    send_frame(48'hA5_07_00_00_00_07);
    idle(10);
    check("t4_err_cmd", 32'(cmd_cnt), 32'd1);
    check("t4_no_wr", 32'(wr_cnt + ok_cnt + csum_cnt), 32'd0);
    clear_tally();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(FRAME1);
    idle(10);
    expect_frame1("t4b");

    // 5: inter-byte timeout after A5 01.
    clear_tally();
    send_byte(8'hA5);
    send_byte(8'h01);
    wait_cyc = 0;
    while (to_cnt == 0 && wait_cyc < TIMEOUT_CYC + 200) begin
      @(posedge clk);
      wait_cyc++;
    end
    idle(10);
    check("t5_err_timeout", 32'(to_cnt), 32'd1);
    check("t5_to_window", 32'(to_lat >= int'(TIMEOUT_CYC) && to_lat <= int'(TIMEOUT_CYC) + 2), 32'd1);
    check("t5_no_wr", 32'(wr_cnt + ok_cnt + csum_cnt + cmd_cnt), 32'd0);
    clear_tally();
    send_frame(FRAME1);
    idle(10);
    expect_frame1("t5b");

    // 6: 256-write fill with a byte arriving mid-fill.
    clear_tally();
    send_frame(48'hA5_02_00_FF_11_EC);
    send_byte(8'h55);
    wait_cyc = 0;
    while (busy && wait_cyc < 400) begin
      @(posedge clk);
      wait_cyc++;
    end
    idle(20);
    check("t6_wr_cnt", 32'(wr_cnt), 32'd256);
    check("t6_busy_cyc", 32'(busy_cnt), 32'd256);
    check("t6_overrun", 32'(ovr_cnt), 32'd1);
    check("t6_frame_ok", 32'(ok_cnt), 32'd1);
    bad_addr = 0;
    bad_data = 0;
    foreach (addr_log[i]) begin
      if (addr_log[i] != 16'(i)) bad_addr++;
      if (data_log[i] != 8'h11) bad_data++;
    end
    check("t6_addr_seq", 32'(bad_addr), 32'd0);
    check("t6_data", 32'(bad_data), 32'd0);
    check("t6_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd255);

    // 6b: asynchronous reset in the middle of a fill.
    clear_tally();
    send_frame(48'hA5_02_00_FF_11_EC);
    wait_cyc = 0;
    @(negedge clk);
    while (!busy && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("t6b_busy_before_rst", 32'({busy, wr_en}), 32'b11);
    rst_n = 1'b0;
    #1;
    check("t6b_rst_now", 32'({wr_en, busy, frame_ok, err_overrun}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    check("t6b_quiet", 32'({wr_en, busy}), 32'd0);
    clear_tally();
    send_frame(FRAME1);
    idle(10);
    expect_frame1("t6c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
